at25010_spi_slave: RTL and testbench

AT25010_SPI_SLAVE -- requirements
Module: at25010_spi_slave

---
 rtl/at25010_spi_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_at25010_spi_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/at25010_spi_slave.sv
// rtl/at25010_spi_slave.sv - AT25010-style 128x8 SPI EEPROM slave (mode 0) with page write and block protect
module at25010_spi_slave #(
  parameter int TWC_CLKS   = 250,
  parameter int PAGE_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       busy,
  output logic [7:0] status,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_rdata
);

  localparam int LB = $clog2(PAGE_BYTES);
  localparam int CW = $clog2(TWC_CLKS + 1);

  typedef enum logic [2:0] {
    IDLE, OPCODE, ADDR, WR_DATA, RD_DATA, WRSR_DATA, IGNORE
  } state_t;

  state_t state, state_n;

  logic cs_meta, cs_s, cs_d;
  logic sclk_meta, sclk_s, sclk_d;
  logic mosi_meta, mosi_s;

  logic [2:0]            bit_cnt;
  logic [6:0]            shift_in;
  logic [7:0]            op;
  logic [6:0]            addr;
  logic                  wel;
  logic [1:0]            bp, pend_bp;
  logic [CW-1:0]         twc_cnt;
  logic [PAGE_BYTES-1:0] mask;
  logic                  got_byte;
  logic [7:0]            tx_buf, tx_sh;
  logic                  tx_load, miso_r, oe_r;
  logic [7:0]            page_buf [PAGE_BYTES];

  // Power-up contents only; reset deliberately leaves the array alone.
  logic [7:0] mem [128] = '{default: 8'hFF};

  logic       cs_fall, cs_rise, sclk_rise, sclk_fall, byte_done, start_wc;
  logic [7:0] rx_byte;
  logic [6:0] addr_inc;

  function automatic logic is_prot(input logic [6:0] a, input logic [1:0] b);
    case (b)
      2'b00:   return 1'b0;
      2'b01:   return a >= 7'h60;
      2'b10:   return a >= 7'h40;
      default: return 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta   <= 1'b1; cs_s   <= 1'b1; cs_d   <= 1'b1;
      sclk_meta <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      mosi_meta <= 1'b0; mosi_s <= 1'b0;
    end else begin
      cs_meta   <= spi_cs_n; cs_s   <= cs_meta;   cs_d   <= cs_s;
      sclk_meta <= spi_sclk; sclk_s <= sclk_meta; sclk_d <= sclk_s;
      mosi_meta <= spi_mosi; mosi_s <= mosi_meta;
    end
  end

  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
  assign rx_byte   = {shift_in, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
  assign addr_inc  = addr + 7'd1;
  assign status    = {4'b0000, bp, wel, busy};
  assign dbg_rdata = mem[dbg_addr];
  assign spi_miso  = (state == RD_DATA) ? miso_r : 1'b0;
  assign spi_miso_oe = oe_r;

  // Write cycle only for a complete, byte-aligned data phase under WEL.
  assign start_wc = cs_rise && wel && got_byte && (bit_cnt == 3'd0) && !busy &&
                    ((state == WR_DATA) || (state == WRSR_DATA));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_s) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   if (cs_fall) state_n = OPCODE;
        OPCODE: if (byte_done) begin
          if (busy && rx_byte != 8'h05) state_n = IGNORE;
          else begin
            case (rx_byte)
              8'h05:        state_n = RD_DATA;
              8'h01:        state_n = WRSR_DATA;
              8'h03, 8'h02: state_n = ADDR;
              default:      state_n = IGNORE;
            endcase
          end
        end
        ADDR:   if (byte_done) state_n = (op == 8'h03) ? RD_DATA : WR_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;  shift_in <= '0;  op      <= '0;  addr    <= '0;
      wel      <= 1'b0; bp      <= 2'b00; pend_bp <= 2'b00;
      busy     <= 1'b0; twc_cnt <= '0;  mask    <= '0;  got_byte <= 1'b0;
      tx_buf   <= '0;  tx_sh    <= '0;  tx_load <= 1'b0;
      miso_r   <= 1'b0; oe_r    <= 1'b0;
    end else begin
      oe_r <= ~cs_s;
      if (cs_s) begin
        bit_cnt <= '0;
        tx_load <= 1'b0;
      end else if (sclk_rise && state != IDLE) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= rx_byte[6:0];
      end
      if (cs_fall) begin
        mask     <= '0;
        got_byte <= 1'b0;
      end

      if (byte_done) begin
        case (state)
          OPCODE: begin
            op <= rx_byte;
            if (!busy) begin
              if (rx_byte == 8'h06) wel <= 1'b1;
              if (rx_byte == 8'h04) wel <= 1'b0;
            end
            if (rx_byte == 8'h05) begin
              tx_buf  <= status;
              tx_load <= 1'b1;
            end
          end
          ADDR: begin
            addr <= rx_byte[6:0];
            if (op == 8'h03) begin
              tx_buf  <= mem[rx_byte[6:0]];
              tx_load <= 1'b1;
            end
          end
          RD_DATA: begin
            tx_load <= 1'b1;
            if (op == 8'h05) tx_buf <= status;
            else begin
              addr   <= addr_inc;
              tx_buf <= mem[addr_inc];
            end
          end
          WR_DATA: begin
            mask[addr[LB-1:0]] <= 1'b1;
            addr     <= {addr[6:LB], addr[LB-1:0] + LB'(1)};
            got_byte <= 1'b1;
          end
          WRSR_DATA: begin
            if (!got_byte) pend_bp <= rx_byte[3:2];
            got_byte <= 1'b1;
          end
          default: ;
        endcase
      end

      // A freshly loaded byte goes out MSB-first starting at the next falling edge.
      if (sclk_fall) begin
        if (tx_load) begin
          miso_r  <= tx_buf[7];
          tx_sh   <= {tx_buf[6:0], 1'b0};
          tx_load <= 1'b0;
        end else begin
          miso_r <= tx_sh[7];
          tx_sh  <= {tx_sh[6:0], 1'b0};
        end
      end

      if (start_wc) begin
        busy    <= 1'b1;
        twc_cnt <= CW'(TWC_CLKS - 1);
        if (state == WRSR_DATA) bp <= pend_bp;
      end else if (busy) begin
        if (twc_cnt == '0) begin
          busy <= 1'b0;
          wel  <= 1'b0;
        end else begin
          twc_cnt <= twc_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_done && state == WR_DATA) page_buf[addr[LB-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst && start_wc && state == WR_DATA) begin
      for (int i = 0; i < PAGE_BYTES; i++) begin
        if (mask[i] && !is_prot({addr[6:LB], LB'(i)}, bp))
          mem[{addr[6:LB], LB'(i)}] <= page_buf[i];
      end
    end
  end

endmodule

// File: tb/tb_at25010_spi_slave.sv
// tb/tb_at25010_spi_slave.sv - randomized self-checking bench for at25010_spi_slave against a transaction-level EEPROM model
module tb_at25010_spi_slave;

  localparam int TWC  = 600;
  localparam int PAGE = 8;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst, cs_n, sclk, mosi;
  logic       miso, oe, busy;
  logic [7:0] status, dbg_rdata;
  logic [6:0] dbg_addr;

  int checks, failures, busy_cycles;

  logic [7:0] m_mem [128];
  logic       m_wel;
  logic [1:0] m_bp;
  logic [7:0] wq [$];
  logic [7:0] rq [$];

  at25010_spi_slave #(.TWC_CLKS(TWC), .PAGE_BYTES(PAGE)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(oe), .busy(busy), .status(status),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (busy) busy_cycles++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    sclk = 1'b0;
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
  endtask

  task automatic xfer_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      tick(HALF);
      r = {r[6:0], miso};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] d, output logic [7:0] r);
    xfer_bits(d, 8, r);
  endtask

  function automatic bit m_prot(input int a);
    case (m_bp)
      2'd0:    return 1'b0;
      2'd1:    return a >= 96;
      2'd2:    return a >= 64;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] m_status(input bit b);
    return {4'b0000, m_bp, m_wel, b};
  endfunction

  task automatic model_write(input int addr);
    int base, off;
    logic [7:0] pg [PAGE];
    bit hit [PAGE];
    if (!m_wel || wq.size() == 0) return;
    addr = addr % 128;
    base = addr - addr % PAGE;
    foreach (hit[i]) hit[i] = 1'b0;
    for (int k = 0; k < wq.size(); k++) begin
      off = (addr % PAGE + k) % PAGE;
      pg[off] = wq[k];
      hit[off] = 1'b1;
    end
    for (int o = 0; o < PAGE; o++)
      if (hit[o] && !m_prot(base + o)) m_mem[base + o] = pg[o];
    m_wel = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] c);
    logic [7:0] r;
    cs_begin(); xfer(c, r); cs_end();
    if (c == 8'h06) m_wel = 1'b1;
    if (c == 8'h04) m_wel = 1'b0;
  endtask

  task automatic do_write(input int addr);
    logic [7:0] r;
    cs_begin(); xfer(8'h02, r); xfer(8'(addr), r);
    foreach (wq[k]) xfer(wq[k], r);
    cs_end();
    model_write(addr);
  endtask

  task automatic do_wrsr(input logic [7:0] d);
    logic [7:0] r;
    cs_begin(); xfer(8'h01, r); xfer(d, r); cs_end();
    if (m_wel) begin m_bp = d[3:2]; m_wel = 1'b0; end
  endtask

  task automatic do_read(input int addr, input int n);
    logic [7:0] r;
    rq.delete();
    cs_begin(); xfer(8'h03, r); xfer(8'(addr), r);
    for (int k = 0; k < n; k++) begin xfer(8'h00, r); rq.push_back(r); end
    cs_end();
  endtask

  task automatic do_rdsr(output logic [7:0] s);
    logic [7:0] r;
    cs_begin(); xfer(8'h05, r); xfer(8'h00, s); cs_end();
  endtask

  task automatic peek(input int a, output logic [7:0] v);
    dbg_addr = 7'(a);
    #1;
    v = dbg_rdata;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 5000 && busy; i++) tick(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_ready: busy=%b still set after 5000 clk, required 0", busy);
    end
  endtask

  task automatic test_reset();
    logic [7:0] s, v;
    int a;
    rst = 1'b1; tick(3); rst = 1'b0; tick(2);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL reset_status: got %h required 00", status); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (oe !== 1'b0 || miso !== 1'b0) begin failures++; $display("FAIL reset_miso: oe=%b miso=%b required 0 0", oe, miso); end
    a = $urandom_range(0, 127);
    peek(a, v);
    checks++; if (v !== m_mem[a]) begin failures++; $display("FAIL init_mem[%0d]: got %h required %h", a, v, m_mem[a]); end
    do_rdsr(s);
    checks++; if (s !== m_status(0)) begin failures++; $display("FAIL rdsr_after_reset: got %h required %h", s, m_status(0)); end
  endtask

  task automatic test_wren();
    logic [7:0] s;
    cs_n = 1'b0; tick(HALF);
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL miso_oe_cs_low: got %b required 1", oe); end
    cs_n = 1'b1; tick(HALF);
    do_cmd(8'h06);
    do_rdsr(s);
    checks++; if (s !== m_status(0)) begin failures++; $display("FAIL rdsr_after_wren: got %h required %h", s, m_status(0)); end
  endtask

  task automatic test_write();
    logic [7:0] s, during;
    during = {4'b0000, m_bp, 2'b11};
    busy_cycles = 0;
    wq = '{8'hA5};
    do_write(8'h05);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_start: got %b required 1", busy); end
    do_rdsr(s);
    checks++; if (s !== during) begin failures++; $display("FAIL rdsr_during_write: got %h required %h", s, during); end
    wait_ready();
    checks++; if (busy_cycles !== TWC) begin failures++; $display("FAIL twc_length: got %0d required %0d", busy_cycles, TWC); end
    do_rdsr(s);
    checks++; if (s !== m_status(0)) begin failures++; $display("FAIL rdsr_after_write: got %h required %h", s, m_status(0)); end
    do_read(8'h05, 1);
    checks++; if (rq[0] !== m_mem[5]) begin failures++; $display("FAIL read_05: got %h required %h", rq[0], m_mem[5]); end
  endtask

  task automatic test_no_wren();
    logic [7:0] v;
    busy_cycles = 0;
    wq = '{8'h5A};
    do_write(8'h05);
    tick(50);
    checks++; if (busy_cycles !== 0) begin failures++; $display("FAIL no_wren_busy: got %0d busy cycles required 0", busy_cycles); end
    peek(5, v);
    checks++; if (v !== m_mem[5]) begin failures++; $display("FAIL no_wren_mem: got %h required %h", v, m_mem[5]); end
  endtask

  task automatic test_page_wrap();
    logic [7:0] v;
    do_cmd(8'h06);
    wq = '{8'h11, 8'h22, 8'h33};
    do_write(8'h06);
    wait_ready();
    foreach (wq[k]) begin
      peek((6 + k) % PAGE, v);
      checks++; if (v !== m_mem[(6 + k) % PAGE]) begin failures++; $display("FAIL page_wrap[%0d]: got %h required %h", (6 + k) % PAGE, v, m_mem[(6 + k) % PAGE]); end
    end
    do_read(8'h7F, 2);
    checks++; if (rq[0] !== m_mem[127]) begin failures++; $display("FAIL read_7f: got %h required %h", rq[0], m_mem[127]); end
    checks++; if (rq[1] !== m_mem[0]) begin failures++; $display("FAIL read_wrap_00: got %h required %h", rq[1], m_mem[0]); end
  endtask

  task automatic test_random_pages();
    logic [7:0] v;
    int a, n;
    for (int it = 0; it < 4; it++) begin
      do_cmd(8'h06);
      a = $urandom_range(0, 255);
      n = $urandom_range(1, 12);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      do_write(a);
      wait_ready();
      for (int j = 0; j < 128; j++) begin
        peek(j, v);
        checks++; if (v !== m_mem[j]) begin failures++; $display("FAIL rand_page it%0d mem[%0d]: got %h required %h", it, j, v, m_mem[j]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, n;
    for (int it = 0; it < 3; it++) begin
      a = $urandom_range(0, 127);
      n = $urandom_range(1, 20);
      do_read(a, n);
      foreach (rq[k]) begin
        checks++; if (rq[k] !== m_mem[(a + k) % 128]) begin failures++; $display("FAIL burst_read it%0d @%0d: got %h required %h", it, (a + k) % 128, rq[k], m_mem[(a + k) % 128]); end
      end
    end
  endtask

  task automatic test_protect();
    logic [7:0] s, v;
    do_cmd(8'h06); do_wrsr(8'h04); wait_ready();
    do_rdsr(s);
    checks++; if (s !== m_status(0)) begin failures++; $display("FAIL rdsr_bp01: got %h required %h", s, m_status(0)); end
    do_cmd(8'h06); wq = '{8'h12}; do_write(8'h70); wait_ready();
    peek(8'h70, v);
    checks++; if (v !== m_mem[8'h70]) begin failures++; $display("FAIL protected_70: got %h required %h", v, m_mem[8'h70]); end
    do_cmd(8'h06); wq = '{8'($urandom)}; do_write(8'h10); wait_ready();
    peek(8'h10, v);
    checks++; if (v !== m_mem[8'h10]) begin failures++; $display("FAIL unprotected_10: got %h required %h", v, m_mem[8'h10]); end
    do_cmd(8'h06); do_wrsr(8'h00); wait_ready();
    do_rdsr(s);
    checks++; if (s !== m_status(0)) begin failures++; $display("FAIL rdsr_bp00: got %h required %h", s, m_status(0)); end
  endtask

  task automatic test_abort();
    logic [7:0] r, s, v;
    do_cmd(8'h06);
    cs_begin(); xfer(8'h02, r); xfer(8'h20, r); xfer_bits(8'hC3, 4, r); cs_end();
    tick(20);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", busy); end
    peek(8'h20, v);
    checks++; if (v !== m_mem[8'h20]) begin failures++; $display("FAIL abort_mem: got %h required %h", v, m_mem[8'h20]); end
    do_rdsr(s);
    checks++; if (s !== m_status(0)) begin failures++; $display("FAIL abort_wel_kept: got %h required %h", s, m_status(0)); end
    busy_cycles = 0;
    wq = '{8'h77};
    do_write(8'h21);
    do_read(8'h21, 1);
    checks++; if (rq[0] !== 8'h00) begin failures++; $display("FAIL read_while_busy: got %h required 00", rq[0]); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_read: got %b required 1", busy); end
    wait_ready();
    checks++; if (busy_cycles !== TWC) begin failures++; $display("FAIL twc_with_read: got %0d required %0d", busy_cycles, TWC); end
    peek(8'h21, v);
    checks++; if (v !== m_mem[8'h21]) begin failures++; $display("FAIL write_21: got %h required %h", v, m_mem[8'h21]); end
  endtask

  task automatic test_reset_mid_cycle();
    logic [7:0] v;
    do_cmd(8'h06);
    wq = '{8'($urandom)};
    do_write(8'h30);
    tick(5);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    m_wel = 1'b0; m_bp = 2'b00;
    checks++; if (busy !== 1'b0 || status !== m_status(0)) begin failures++; $display("FAIL reset_mid: busy=%b status=%h required 0 %h", busy, status, m_status(0)); end
    peek(8'h30, v);
    checks++; if (v !== m_mem[8'h30]) begin failures++; $display("FAIL reset_keeps_mem: got %h required %h", v, m_mem[8'h30]); end
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; dbg_addr = '0;
    checks = 0; failures = 0; busy_cycles = 0;
    foreach (m_mem[i]) m_mem[i] = 8'hFF;
    m_wel = 1'b0; m_bp = 2'b00;
    test_reset();
    test_wren();
    test_write();
    test_no_wren();
    test_page_wrap();
    test_random_pages();
    test_back_to_back();
    test_protect();
    test_abort();
    test_reset_mid_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
